imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_format_mux.sv | 30 +++
 rtl/imm_gen_pipe.sv | 114 +++++++++++
 tb/tb_imm_gen_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate-generator shared definitions: format select encodings and default datapath width.
// Pure declarations; no logic, no timing.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_CSR   = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

endpackage

// File: rtl/imm_format_mux.sv
// Combinational immediate decode from instr[31:7] and a format select; zero latency.
// No handshake; the reserved select yields imm = 0 with illegal set.
module imm_format_mux
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // instr holds instruction bits [31:7], so architectural bit k sits at index k-7.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:     imm = XLEN'($signed(instr[24:13]));
      IMM_S:     imm = XLEN'($signed({instr[24:18], instr[4:0]}));
      IMM_B:     imm = XLEN'($signed({instr[24], instr[0], instr[23:18], instr[4:1], 1'b0}));
      IMM_J:     imm = XLEN'($signed({instr[24], instr[12:5], instr[13], instr[23:14], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[24:5], 12'b0}));
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[18:13]) : XLEN'(instr[17:13]);
      IMM_CSR:   imm = XLEN'(instr[12:8]);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with optional pc + imm target; latency STAGES cycles, one entry/cycle.
// Valid/ready handshake: a stage loads when empty or draining; flush kills every in-flight entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int STAGES = 1,
  parameter int PC_ADD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            s1_vld_q;
  logic            s1_adv;

  imm_format_mux #(.XLEN(XLEN)) u_fmt (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign in_ready = !s1_vld_q || s1_adv;

  generate
    if (STAGES == 1) begin : g_one
      logic [XLEN-1:0] imm_q, tgt_q, tgt_d;
      logic            ill_q;

      assign tgt_d  = (PC_ADD != 0) ? pc + dec_imm : '0;
      assign s1_adv = s1_vld_q && out_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_vld_q <= 1'b0;
          imm_q    <= '0;
          tgt_q    <= '0;
          ill_q    <= 1'b0;
        end else begin
          if (flush)         s1_vld_q <= 1'b0;
          else if (in_ready) s1_vld_q <= in_valid;
          if (in_ready && in_valid) begin
            imm_q <= dec_imm;
            tgt_q <= tgt_d;
            ill_q <= dec_ill;
          end
        end
      end

      assign out_valid = s1_vld_q;
      assign imm       = imm_q;
      assign target    = tgt_q;
      assign illegal   = ill_q;
    end else begin : g_two
      logic [XLEN-1:0] s1_imm_q, s1_pc_q;
      logic            s1_ill_q;
      logic            s2_vld_q, s2_ill_q, s2_load;
      logic [XLEN-1:0] s2_imm_q, s2_tgt_q, s2_tgt_d;

      // Stage 2 takes stage 1 whenever it is empty or its entry is consumed.
      assign s2_load  = !s2_vld_q || out_ready;
      assign s1_adv   = s1_vld_q && s2_load;
      assign s2_tgt_d = (PC_ADD != 0) ? s1_pc_q + s1_imm_q : '0;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_vld_q <= 1'b0;
          s1_imm_q <= '0;
          s1_pc_q  <= '0;
          s1_ill_q <= 1'b0;
          s2_vld_q <= 1'b0;
          s2_imm_q <= '0;
          s2_tgt_q <= '0;
          s2_ill_q <= 1'b0;
        end else begin
          if (flush)         s1_vld_q <= 1'b0;
          else if (in_ready) s1_vld_q <= in_valid;
          if (in_ready && in_valid) begin
            s1_imm_q <= dec_imm;
            s1_pc_q  <= pc;
            s1_ill_q <= dec_ill;
          end
          if (flush)        s2_vld_q <= 1'b0;
          else if (s2_load) s2_vld_q <= s1_vld_q;
          if (s2_load && s1_vld_q) begin
            s2_imm_q <= s1_imm_q;
            s2_tgt_q <= s2_tgt_d;
            s2_ill_q <= s1_ill_q;
          end
        end
      end

      assign out_valid = s2_vld_q;
      assign imm       = s2_imm_q;
      assign target    = s2_tgt_q;
      assign illegal   = s2_ill_q;
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit single-stage and a 64-bit two-stage instance share stimulus;
// a queue-based reference model with acceptance/consumption cycle tracking checks both every cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  imm_src;
  logic [63:0] pc;

  logic        a_vld, a_rdy, a_ill;
  logic [31:0] a_imm, a_tgt;
  logic        b_vld, b_rdy, b_ill;
  logic [63:0] b_imm, b_tgt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int stall_cnt;
  int lo_s = -1, lo_e = -2;
  bit or_rand = 1'b0;
  int lc[2] = '{-100, -100};

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
    int          acc;
  } ent_t;
  ent_t q0[$];
  ent_t q1[$];

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .PC_ADD(1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
    .instr(instr), .imm_src(imm_src), .pc(pc[31:0]), .out_valid(a_vld),
    .out_ready(out_ready), .imm(a_imm), .target(a_tgt), .illegal(a_ill)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2), .PC_ADD(1)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
    .instr(instr), .imm_src(imm_src), .pc(pc), .out_valid(b_vld),
    .out_ready(out_ready), .imm(b_imm), .target(b_tgt), .illegal(b_ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  // Reference immediate straight from the format table, using two's-complement arithmetic.
  function automatic void ref_imm(input logic [24:0] ins, input logic [2:0] src, input int xl,
                                  output logic [63:0] v, output logic ill);
    logic [31:0] w;
    w   = {ins, 7'b0};
    ill = 1'b0;
    case (src)
      3'd0: v = sext(64'(w[31:20]), 12);
      3'd1: v = sext(64'({w[31:25], w[11:7]}), 12);
      3'd2: v = sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      3'd3: v = sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      3'd4: v = sext(64'({w[31:12], 12'b0}), 32);
      3'd5: v = (xl == 32) ? 64'(w[24:20]) : 64'(w[25:20]);
      3'd6: v = 64'(w[19:15]);
      default: begin v = 64'd0; ill = 1'b1; end
    endcase
    if (xl == 32) v = v & 64'hFFFF_FFFF;
  endfunction

  task automatic mon(input int d, input logic ov, input logic ir,
                     input logic [63:0] oi, input logic [63:0] ot, input logic oil);
    int st, xl, n;
    ent_t f, e;
    logic eov, eir, ill;
    logic [63:0] v, pv;
    string p;
    st = (d == 0) ? 1 : 2;
    xl = (d == 0) ? 32 : 64;
    p  = (d == 0) ? "a" : "b";
    n  = (d == 0) ? q0.size() : q1.size();
    f  = '{64'd0, 64'd0, 1'b0, 0};
    if (n > 0) f = (d == 0) ? q0[0] : q1[0];
    eir = (n < st) || out_ready;
    eov = (n > 0) && (cyc >= f.acc + st) && (cyc >= lc[d] + 1);
    chk({p, "_in_ready"}, 64'(ir), 64'(eir));
    chk({p, "_out_valid"}, 64'(ov), 64'(eov));
    if (eov) begin
      chk({p, "_imm"}, oi, f.imm);
      chk({p, "_target"}, ot, f.tgt);
      chk({p, "_illegal"}, 64'(oil), 64'(f.ill));
    end
    if (flush) begin
      if (d == 0) q0.delete(); else q1.delete();
      lc[d] = -100;
    end else begin
      if (eov && out_ready) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        lc[d] = cyc;
      end
      if (in_valid && eir) begin
        ref_imm(instr, imm_src, xl, v, ill);
        pv = (xl == 32) ? {32'd0, pc[31:0]} : pc;
        e.imm = v;
        e.ill = ill;
        e.tgt = pv + v;
        if (xl == 32) e.tgt[63:32] = 32'd0;
        e.acc = cyc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_a_out_valid", 64'(a_vld), 64'd0);
      chk("rst_b_out_valid", 64'(b_vld), 64'd0);
      chk("rst_a_in_ready", 64'(a_rdy), 64'd1);
      chk("rst_b_in_ready", 64'(b_rdy), 64'd1);
      chk("rst_b_imm", b_imm, 64'd0);
      chk("rst_b_target", b_tgt, 64'd0);
      chk("rst_a_illegal", 64'(a_ill), 64'd0);
      q0.delete();
      q1.delete();
      lc = '{-100, -100};
    end else begin
      mon(0, a_vld, a_rdy, {32'd0, a_imm}, {32'd0, a_tgt}, a_ill);
      mon(1, b_vld, b_rdy, b_imm, b_tgt, b_ill);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (or_rand) out_ready = 1'($urandom_range(0, 1));
      else         out_ready = !(cyc >= lo_s && cyc <= lo_e);
    end
  end

  // Presents one entry and holds it until the two-stage instance accepts it.
  task automatic send(input logic [24:0] ins, input logic [2:0] src, input logic [63:0] p);
    logic rdy;
    int   k;
    in_valid = 1'b1; instr = ins; imm_src = src; pc = p;
    rdy = 1'b0;
    k   = 0;
    while (!rdy && k < 30) begin
      @(negedge clk);
      rdy = b_rdy;
      if (!rdy) stall_cnt++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0; pc = '0;
    #1;
    chk("t0_a_out_valid", 64'(a_vld), 64'd0);
    chk("t0_b_in_ready", 64'(b_rdy), 64'd1);
    chk("t0_a_target", {32'd0, a_tgt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Known-answer vectors: addi -1, B -4096, U 0x80000, shamt 63, reserved.
    in_valid = 1'b1; instr = 25'h1FFE000; imm_src = 3'd0; pc = 64'h100;
    @(posedge clk); #1;
    chk("kat_addi_a_imm", {32'd0, a_imm}, 64'hFFFF_FFFF);
    chk("kat_addi_a_target", {32'd0, a_tgt}, 64'hFF);
    instr = 25'h1000000; imm_src = 3'd2; pc = 64'h1000;
    @(posedge clk); #1;
    chk("kat_b_a_imm", {32'd0, a_imm}, 64'hFFFF_F000);
    chk("kat_b_a_target", {32'd0, a_tgt}, 64'h0);
    chk("kat_addi_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("kat_addi_b_target", b_tgt, 64'hFF);
    instr = 25'h1000000; imm_src = 3'd4; pc = 64'h0;
    @(posedge clk); #1;
    chk("kat_u_a_imm", {32'd0, a_imm}, 64'h8000_0000);
    chk("kat_b_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_F000);
    chk("kat_b_b_target", b_tgt, 64'h0);
    instr = 25'h007E000; imm_src = 3'd5; pc = 64'h0;
    @(posedge clk); #1;
    chk("kat_shamt_a_imm", {32'd0, a_imm}, 64'd31);
    chk("kat_u_b_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    instr = 25'h1ABCDEF; imm_src = 3'd7; pc = 64'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("kat_rsvd_a_illegal", 64'(a_ill), 64'd1);
    chk("kat_rsvd_a_imm", {32'd0, a_imm}, 64'd0);
    chk("kat_rsvd_a_target", {32'd0, a_tgt}, 64'h1234);
    chk("kat_shamt_b_imm", b_imm, 64'd63);
    @(posedge clk); #1;
    chk("kat_rsvd_b_illegal", 64'(b_ill), 64'd1);
    chk("kat_rsvd_b_imm", b_imm, 64'd0);
    chk("kat_rsvd_b_target", b_tgt, 64'h1234);

    // Four back-to-back entries with downstream stalled for three cycles.
    repeat (3) @(posedge clk);
    #1;
    lo_s = cyc + 3;
    lo_e = cyc + 5;
    stall_cnt = 0;
    for (int i = 0; i < 4; i++)
      send(25'($urandom), 3'($urandom_range(0, 6)), {$urandom(), $urandom()});
    chk("b2b_stall_cycles", 64'(stall_cnt), 64'd3);
    repeat (6) @(posedge clk);
    #1;

    // Flush with two entries in flight and a new entry offered in the same cycle.
    lo_s = cyc + 1;
    lo_e = cyc + 4;
    for (int i = 0; i < 2; i++)
      send(25'($urandom), 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    flush = 1'b1; in_valid = 1'b1; instr = 25'($urandom); imm_src = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_a_out_valid", 64'(a_vld), 64'd0);
    chk("flush_b_out_valid", 64'(b_vld), 64'd0);
    repeat (6) @(posedge clk);
    #1;

    // Reset asserted mid-cycle while entries are visible, then latency after release.
    lo_s = cyc + 1;
    lo_e = cyc + 3;
    for (int i = 0; i < 2; i++)
      send(25'($urandom), 3'($urandom_range(0, 6)), {$urandom(), $urandom()});
    chk("pre_rst_b_out_valid", 64'(b_vld), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_a_out_valid", 64'(a_vld), 64'd0);
    chk("async_rst_b_out_valid", 64'(b_vld), 64'd0);
    chk("async_rst_b_imm", b_imm, 64'd0);
    chk("async_rst_b_in_ready", 64'(b_rdy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    send(25'($urandom), 3'($urandom_range(0, 6)), {$urandom(), $urandom()});
    chk("post_rst_a_out_valid", 64'(a_vld), 64'd1);
    chk("post_rst_b_out_valid_early", 64'(b_vld), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_b_out_valid", 64'(b_vld), 64'd1);

    // Random traffic with random backpressure and occasional flush.
    or_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      instr    = 25'($urandom);
      imm_src  = 3'($urandom_range(0, 7));
      pc       = {$urandom(), $urandom()};
      flush    = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    or_rand  = 1'b0;
    lo_s = -1;
    lo_e = -2;
    repeat (6) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
